// File: rtl/ahb_pkg.sv
// Shared AHB-lite types and constants for the core-side master port.
// Transfer encodings, region tags, master FSM states and the alignment rule.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [7:0] ROM_REGION = 8'hA0;
   localparam logic [7:0] RAM_REGION = 8'hB0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_ERR
   } mst_state_t;

   // Size 3 has no legal encoding, so it never passes.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lsb);
      logic ok;
      ok = 1'b0;
      if ({1'b0, size} == HSIZE_BYTE)      ok = 1'b1;
      else if ({1'b0, size} == HSIZE_HALF) ok = ~addr_lsb[0];
      else if ({1'b0, size} == HSIZE_WORD) ok = (addr_lsb == 2'b00);
      return ok;
   endfunction

endpackage

// File: rtl/ahb_master_port_if.sv
// Core request/response handshake plus AHB-lite master bus, bundled as one interface.
// The master modport is the port block's view; slave is the core+bus-slave view.
interface ahb_master_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_fetch;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready;
   logic              hresp;

   modport master (
      input  req_valid, req_write, req_fetch, req_size, req_addr, req_wdata,
      input  hrdata, hready, hresp,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
   );

   modport slave (
      output req_valid, req_write, req_fetch, req_size, req_addr, req_wdata,
      output hrdata, hready, hresp,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
   );
endinterface

// File: rtl/ahb_wait_timer.sv
// Data-phase wait-state counter; flags the cycle on which the wait limit is reached.
// Only instantiated when AHB_TIMEOUT_EN is defined.
module ahb_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic stall,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (!run) begin
         count_reg <= '0;
      end else if (stall) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // Fires during the stall cycle that brings the count up to LIMIT.
   assign expired = run && stall && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/ahb_master_port.sv
// Single-transfer AHB-lite initiator for the core memory handshake.
// Optional data-phase timeout is enabled by defining AHB_TIMEOUT_EN.
module ahb_master_port
   import ahb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               reset,
   ahb_master_port_if.master bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   mst_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              write_reg;
   logic              fetch_reg;
   logic [1:0]        size_reg;
   logic [DATA_W-1:0] wdata_reg;

   logic              req_ready_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg, rsp_err_next;
   logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
   logic [DATA_W-1:0] hwdata_reg;
   htrans_t           htrans_reg;

   logic aligned;
   logic latch_en;
   logic timeout;

   assign aligned = is_aligned(bus.req_size, bus.req_addr[1:0]);

`ifdef AHB_TIMEOUT_EN
   ahb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .run     (state_reg == ST_DATA),
      .stall   (!bus.hready),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      latch_en       = 1'b0;
      rsp_err_next   = rsp_err_reg;
      rsp_rdata_next = rsp_rdata_reg;
      unique case (state_reg)
         // RESP and ERR accept a new request exactly like IDLE.
         ST_IDLE, ST_RESP, ST_ERR: begin
            if (bus.req_valid) begin
               if (aligned) begin
                  latch_en   = 1'b1;
                  state_next = ST_ADDR;
               end else begin
                  state_next     = ST_ERR;
                  rsp_err_next   = 1'b1;
                  rsp_rdata_next = '0;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (bus.hready) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bus.hready) begin
               state_next     = ST_RESP;
               rsp_err_next   = bus.hresp;
               rsp_rdata_next = (!write_reg && !bus.hresp) ? bus.hrdata : '0;
            end else if (timeout) begin
               state_next     = ST_RESP;
               rsp_err_next   = 1'b1;
               rsp_rdata_next = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         write_reg     <= 1'b0;
         fetch_reg     <= 1'b0;
         size_reg      <= 2'b00;
         wdata_reg     <= '0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
         htrans_reg    <= HTRANS_IDLE;
         hwdata_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (latch_en) begin
            addr_reg  <= bus.req_addr;
            write_reg <= bus.req_write;
            fetch_reg <= bus.req_fetch;
            size_reg  <= bus.req_size;
            wdata_reg <= bus.req_wdata;
         end
         // Output registers are loaded from the next state so they line up with it.
         req_ready_reg <= (state_next inside {ST_IDLE, ST_RESP, ST_ERR});
         rsp_valid_reg <= (state_next inside {ST_RESP, ST_ERR});
         rsp_err_reg   <= rsp_err_next;
         rsp_rdata_reg <= rsp_rdata_next;
         htrans_reg    <= (state_next == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
         hwdata_reg    <= (state_next == ST_DATA && write_reg) ? wdata_reg : '0;
      end
   end

   assign bus.req_ready = req_ready_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.haddr     = addr_reg;
   assign bus.htrans    = htrans_reg;
   assign bus.hwrite    = write_reg;
   assign bus.hsize     = {1'b0, size_reg};
   assign bus.hburst    = HBURST_SINGLE;
   assign bus.hprot     = {3'b001, ~fetch_reg};
   assign bus.hwdata    = hwdata_reg;

endmodule
